// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM state type and prefetch-queue entry layout for the fetch unit.
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned IWIDTH   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no imem request outstanding
    ST_WAIT = 2'd1,  // one request outstanding, response will be queued
    ST_DROP = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [IWIDTH-1:0]   instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: control from execute/decode, imem bus, decode output.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                fu_i_ce;
  logic                fu_i_redirect;
  logic [PC_WIDTH-1:0] fu_i_redirect_pc;
  logic                fu_i_stall;
  logic                fu_o_im_req;
  logic [PC_WIDTH-1:0] fu_o_im_addr;
  logic                fu_i_im_valid;
  logic [IWIDTH-1:0]   fu_i_im_instr;
  logic                fu_o_ce;
  logic [PC_WIDTH-1:0] fu_o_pc;
  logic [IWIDTH-1:0]   fu_o_instr;

  modport master (
    input  fu_i_ce, fu_i_redirect, fu_i_redirect_pc, fu_i_stall,
    input  fu_i_im_valid, fu_i_im_instr,
    output fu_o_im_req, fu_o_im_addr, fu_o_ce, fu_o_pc, fu_o_instr
  );

  modport slave (
    output fu_i_ce, fu_i_redirect, fu_i_redirect_pc, fu_i_stall,
    output fu_i_im_valid, fu_i_im_instr,
    input  fu_o_im_req, fu_o_im_addr, fu_o_ce, fu_o_pc, fu_o_instr
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: power-of-two circular buffer with flush; head reads zero when empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         rdata
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Next pointer/count/storage; flush wins over push and pop.
  always_comb begin
    do_push  = push && (count_q != (AW+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head read, zero when empty.
  always_comb begin
    count = count_q;
    rdata = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a prefetch queue to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4)
) (
  input logic         d_clk,
  input logic         d_rst,
  fetch_unit_if.master fu
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]       count;
  logic [CW:0]         occupancy;
  logic                rsp_take, im_req, push, pop, q_valid;
  fetch_entry_t        wr_entry, head;

  // Issue and queue control; an in-flight WAIT response counts as an occupied slot.
  always_comb begin
    rsp_take  = (state_q == ST_WAIT) && fu.fu_i_im_valid;
    occupancy = {1'b0, count} + (CW+1)'(state_q == ST_WAIT);
    im_req    = d_rst && fu.fu_i_ce && !fu.fu_i_redirect
                && (occupancy < (CW+1)'(DEPTH))
                && ((state_q == ST_IDLE) || rsp_take);
    q_valid   = (count != '0);
    push      = rsp_take && !fu.fu_i_redirect;
    pop       = q_valid && !fu.fu_i_redirect && !fu.fu_i_stall;
    wr_entry  = '{pc: req_pc_q, instr: fu.fu_i_im_instr};
  end

  // Next FSM state and PCs; redirect preempts everything else.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (fu.fu_i_redirect) begin
      pc_d = fu.fu_i_redirect_pc;
      case (state_q)
        ST_WAIT, ST_DROP: state_d = fu.fu_i_im_valid ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = im_req ? ST_WAIT : ST_IDLE;
        ST_WAIT: if (fu.fu_i_im_valid) state_d = im_req ? ST_WAIT : ST_IDLE;
        ST_DROP: if (fu.fu_i_im_valid) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (im_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
      end
    end
  end

  // FSM and PC registers.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk  (d_clk),
    .rst_n(d_rst),
    .push (push),
    .pop  (pop),
    .flush(fu.fu_i_redirect),
    .wdata(wr_entry),
    .count(count),
    .rdata(head)
  );

  // Drive the bus outputs.
  always_comb begin
    fu.fu_o_im_req  = im_req;
    fu.fu_o_im_addr = pc_q;
    fu.fu_o_ce      = q_valid && !fu.fu_i_redirect;
    fu.fu_o_pc      = head.pc;
    fu.fu_o_instr   = head.instr;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-004 SHALL have port d_clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port d_rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fu_i_ce  in  1  fetch enable; low blocks new imem requests only.
REQ-007 SHALL have port fu_i_redirect  in  1  PC change from execute (taken branch/jump/jr).
REQ-008 SHALL have port fu_i_redirect_pc  in  PC_WIDTH  redirect target.
REQ-009 SHALL have port fu_i_stall  in  1  decode load-use stall; holds queue head.
REQ-010 SHALL have port fu_o_im_req  out  1  imem request, accepted same cycle.
REQ-011 SHALL have port fu_o_im_addr  out  PC_WIDTH  imem request address.
REQ-012 SHALL have port fu_i_im_valid  in  1  imem response valid, >=1 cycle after request, in order.
REQ-013 SHALL have port fu_i_im_instr  in  IWIDTH  imem response instruction.
REQ-014 SHALL have ports fu_o_ce (1), fu_o_pc (PC_WIDTH), fu_o_instr (IWIDTH), all out: instruction to decode.

Function
REQ-015 SHALL keep fetch PC pc_q; fu_o_im_addr = pc_q.
REQ-016 SHALL keep at most one imem request outstanding.
REQ-017 SHALL keep FSM states IDLE (none outstanding), WAIT (one outstanding), DROP (outstanding response to discard).
REQ-018 SHALL assert fu_o_im_req combinationally iff fu_i_ce, !fu_i_redirect, count+outstanding_after_response < DEPTH, and state IDLE or (WAIT with fu_i_im_valid).
REQ-019 SHALL, on request, latch req_pc <= pc_q, pc_q <= pc_q + PC_STEP (mod 2^PC_WIDTH), and enter/stay WAIT.
REQ-020 SHALL, in WAIT with fu_i_im_valid and no redirect, push {req_pc, fu_i_im_instr}; go IDLE if no new request.
REQ-021 SHALL ignore fu_i_im_valid in IDLE.
REQ-022 SHALL drive fu_o_ce = queue non-empty & !fu_i_redirect; fu_o_pc/fu_o_instr = head entry (zero when empty).
REQ-023 SHALL pop head when fu_o_ce & !fu_i_stall; push and pop in the same cycle leave count unchanged.
REQ-024 SHALL never overflow: the issue rule (REQ-018) guarantees a slot for every response.
REQ-025 SHALL give fu_i_redirect top priority: flush queue (count 0), pc_q <= fu_i_redirect_pc, no push, no pop, no request that cycle.
REQ-026 SHALL, on redirect in WAIT without fu_i_im_valid, go DROP; with fu_i_im_valid same cycle, discard it and go IDLE.
REQ-027 SHALL, in DROP, discard the next fu_i_im_valid and go IDLE; a further redirect in DROP updates pc_q only.
REQ-028 SHALL give latency: redirect at cycle N -> request to target at N+1 (IDLE) -> fu_o_ce at first cycle after response.
REQ-029 SHALL sustain one instruction per cycle with a 1-cycle imem and no stall.

Reset
REQ-030 SHALL, while d_rst low, force state IDLE, pc_q RESET_PC, count/pointers 0, fu_o_ce 0, fu_o_pc 0, fu_o_instr 0, fu_o_im_req 0.
REQ-031 SHALL abandon any outstanding request on reset; a response arriving after release in IDLE is ignored (REQ-021).

Structure
REQ-032 SHALL take PC_WIDTH and IWIDTH from the shared defines header; FSM state encodings are localparams.
REQ-033 SHALL instantiate one sub-module fetch_fifo (DEPTH x PC_WIDTH+IWIDTH, push/pop/flush, count, head read).

Verification
REQ-034 SHALL check reset: RESET_PC=0, release, 1-cycle imem -> im_addr 0,4,8,12 on consecutive cycles; fu_o_pc 0,4,8 with matching instr.
REQ-035 SHALL check stall: hold fu_i_stall 6 cycles -> head unchanged, at most 4 entries queued, im_req drops at full; release -> in-order drain, none lost.
REQ-036 SHALL check redirect with 3-cycle imem: redirect to 0x100 while WAIT -> state DROP, stale response discarded, next im_addr 0x100, fu_o_pc 0x100 first out.
REQ-037 SHALL check redirect coinciding with fu_i_im_valid and pop -> response discarded, queue empty, fu_o_ce 0 that cycle, IDLE.
REQ-038 SHALL check fu_i_ce low -> no new requests, outstanding response still enqueued, queue drains normally.
REQ-039 SHALL check wrap: pc_q = 2^PC_WIDTH-4 -> next im_addr 0; asynchronous reset mid-WAIT -> all outputs 0 immediately.
